// File: rtl/QuplsPkg.sv
// Shared rename-stage types: architectural and physical register numbers.
// Widths are fixed by the default register-file sizes below.
package QuplsPkg;
  localparam int NAREG = 128;
  localparam int NPREG = 256;

  typedef logic [6:0] aregno_t;
  typedef logic [7:0] pregno_t;
endpackage

// File: rtl/qupls_rename_stage_free_list.sv
// Circular FIFO of unallocated physical registers; pop data is the head, valid when !empty.
// Push and pop may share a cycle; a push into a full list without a pop is dropped and flagged.
module qupls_free_list
  import QuplsPkg::*;
#(
  parameter int NAREG = QuplsPkg::NAREG,
  parameter int NPREG = QuplsPkg::NPREG,
  localparam int DEPTH = NPREG - NAREG,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  pregno_t       push_preg,
  input  logic          pop,
  output pregno_t       pop_preg,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          err
);
  localparam logic [7:0]    LAST = 8'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  pregno_t       mem_q [DEPTH];
  pregno_t       mem_d [DEPTH];
  logic [7:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic          push_ok;

  assign pop_preg = mem_q[head_q[AW-1:0]];
  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign err      = err_q;

  // Register 0 is the hardwired r0 mapping and never enters the list.
  assign push_ok = push && (push_preg != '0) && ((count_q != FULL) || pop);

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    err_d   = err_q;
    if (push_ok) begin
      mem_d[tail_q[AW-1:0]] = push_preg;
      tail_d = (tail_q == LAST) ? 8'd0 : tail_q + 8'd1;
    end
    if (pop) begin
      head_d = (head_q == LAST) ? 8'd0 : head_q + 8'd1;
    end
    if (push_ok && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push_ok && pop) begin
      count_d = count_q - 1'b1;
    end
    if (push && (push_preg != '0) && (count_q == FULL) && !pop) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= pregno_t'(NAREG + i);
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= FULL;
      err_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: rtl/qupls_rename_stage.sv
// Register rename: RAT lookup, free-list allocation and one output register.
// Latency 1 cycle; outputs hold while out_v & !out_rdy, and in_rdy drops when a target cannot be allocated.
module qupls_rename_stage
  import QuplsPkg::*;
#(
  parameter int NAREG = QuplsPkg::NAREG,
  parameter int NPREG = QuplsPkg::NPREG
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    in_v,
  output logic    in_rdy,
  input  aregno_t Ra,
  input  aregno_t Rb,
  input  aregno_t Rt,
  input  logic    Rt_v,
  output logic    out_v,
  input  logic    out_rdy,
  output pregno_t pRa,
  output pregno_t pRb,
  output pregno_t pRt,
  output pregno_t pRt_old,
  output logic    out_Rt_v,
  input  logic    free_v,
  input  pregno_t free_preg,
  output logic    fl_empty,
  output logic    fl_err
);
  localparam int CW = $clog2(NPREG - NAREG + 1);

  pregno_t       rat_q [NAREG];
  pregno_t       rat_d [NAREG];
  logic          out_v_q, out_v_d, out_rt_v_q, out_rt_v_d;
  pregno_t       pra_q, pra_d, prb_q, prb_d, prt_q, prt_d, prt_old_q, prt_old_d;
  logic          eff_rt_v, in_xfer, fl_pop;
  pregno_t       fl_head;
  logic [CW-1:0] fl_count;

  assign eff_rt_v = Rt_v && (Rt != '0);
  assign in_rdy   = (!out_v_q || out_rdy) && (!fl_empty || !eff_rt_v);
  assign in_xfer  = in_v && in_rdy;
  assign fl_pop   = in_xfer && eff_rt_v;

  qupls_free_list #(.NAREG(NAREG), .NPREG(NPREG)) u_fl (
    .clk       (clk),
    .rst       (rst),
    .push      (free_v),
    .push_preg (free_preg),
    .pop       (fl_pop),
    .pop_preg  (fl_head),
    .count     (fl_count),
    .empty     (fl_empty),
    .err       (fl_err)
  );

  // Sources are looked up from rat_q, so Ra == Rt sees the mapping before this update.
  always_comb begin
    rat_d      = rat_q;
    out_v_d    = out_v_q;
    out_rt_v_d = out_rt_v_q;
    pra_d      = pra_q;
    prb_d      = prb_q;
    prt_d      = prt_q;
    prt_old_d  = prt_old_q;
    if (in_xfer) begin
      out_v_d    = 1'b1;
      out_rt_v_d = eff_rt_v;
      pra_d      = rat_q[Ra];
      prb_d      = rat_q[Rb];
      prt_d      = eff_rt_v ? fl_head : '0;
      prt_old_d  = eff_rt_v ? rat_q[Rt] : '0;
      if (eff_rt_v) begin
        rat_d[Rt] = fl_head;
      end
    end else if (out_rdy) begin
      out_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NAREG; i++) begin
        rat_q[i] <= pregno_t'(i);
      end
      out_v_q    <= 1'b0;
      out_rt_v_q <= 1'b0;
      pra_q      <= '0;
      prb_q      <= '0;
      prt_q      <= '0;
      prt_old_q  <= '0;
    end else begin
      rat_q      <= rat_d;
      out_v_q    <= out_v_d;
      out_rt_v_q <= out_rt_v_d;
      pra_q      <= pra_d;
      prb_q      <= prb_d;
      prt_q      <= prt_d;
      prt_old_q  <= prt_old_d;
    end
  end

  assign out_v    = out_v_q;
  assign out_Rt_v = out_rt_v_q;
  assign pRa      = pra_q;
  assign pRb      = prb_q;
  assign pRt      = prt_q;
  assign pRt_old  = prt_old_q;
endmodule

// File: tb/tb_qupls_rename_stage.sv
// Directed bench for qupls_rename_stage: stimulus pushes expected renames, a monitor checks each output transfer.
module tb_qupls_rename_stage;
  import QuplsPkg::*;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  logic    in_v = 1'b0, in_rdy;
  aregno_t Ra = '0, Rb = '0, Rt = '0;
  logic    Rt_v = 1'b0;
  logic    out_v, out_rdy = 1'b1;
  pregno_t pRa, pRb, pRt, pRt_old;
  logic    out_Rt_v;
  logic    free_v = 1'b0;
  pregno_t free_preg = '0;
  logic    fl_empty, fl_err;

  qupls_rename_stage dut (
    .clk(clk), .rst(rst), .in_v(in_v), .in_rdy(in_rdy),
    .Ra(Ra), .Rb(Rb), .Rt(Rt), .Rt_v(Rt_v),
    .out_v(out_v), .out_rdy(out_rdy),
    .pRa(pRa), .pRb(pRb), .pRt(pRt), .pRt_old(pRt_old), .out_Rt_v(out_Rt_v),
    .free_v(free_v), .free_preg(free_preg), .fl_empty(fl_empty), .fl_err(fl_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pra, prb, prt, old;
    logic       rtv;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (!rst && out_v && out_rdy) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pRa", 32'(pRa), 32'(e.pra));
        chk("pRb", 32'(pRb), 32'(e.prb));
        chk("pRt", 32'(pRt), 32'(e.prt));
        chk("pRt_old", 32'(pRt_old), 32'(e.old));
        chk("out_Rt_v", 32'(out_Rt_v), 32'(e.rtv));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input int ra, input int rb, input int rt, input bit rtv,
                       input int e_pra, input int e_prb, input int e_prt, input int e_old);
    exp_t e;
    int   n = 0;
    Ra = aregno_t'(ra); Rb = aregno_t'(rb); Rt = aregno_t'(rt); Rt_v = rtv; in_v = 1'b1;
    e.pra = 8'(e_pra); e.prb = 8'(e_prb); e.prt = 8'(e_prt); e.old = 8'(e_old);
    e.rtv = rtv && (rt != 0);
    forever begin
      @(negedge clk);
      if (in_rdy) begin
        sb.push_back(e);
        break;
      end
      n++;
      if (n > 50) begin
        chk("issue_timeout", 32'd1, 32'd0);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_v = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(2);
    rst = 1'b0;
    #1;
    chk("rst_out_v", 32'(out_v), 0);
    chk("rst_pRt", 32'(pRt), 0);
    chk("rst_pRt_old", 32'(pRt_old), 0);
    chk("rst_pRa", 32'(pRa), 0);
    chk("rst_out_Rt_v", 32'(out_Rt_v), 0);
    chk("rst_fl_err", 32'(fl_err), 0);
    chk("rst_fl_empty", 32'(fl_empty), 0);
    chk("rst_count", 32'(dut.u_fl.count), 128);
    chk("rst_in_rdy", 32'(in_rdy), 1);

    issue(1, 2, 5, 1, 1, 2, 128, 5);
    issue(5, 5, 6, 1, 128, 128, 129, 6);
    issue(6, 3, 6, 1, 129, 3, 130, 129);
    issue(7, 0, 0, 1, 7, 0, 0, 0);
    chk("count_r0", 32'(dut.u_fl.count), 125);

    // Backpressure: hold A in the output register while B waits.
    idle(1);
    out_rdy = 1'b0;
    issue(2, 6, 8, 1, 2, 130, 131, 8);
    Ra = 7'd8; Rb = 7'd1; Rt = 7'd9; Rt_v = 1'b1; in_v = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_in_rdy", 32'(in_rdy), 0);
      chk("stall_out_v", 32'(out_v), 1);
      chk("stall_pRt", 32'(pRt), 131);
      chk("stall_pRt_old", 32'(pRt_old), 8);
      @(posedge clk); #1;
    end
    out_rdy = 1'b1;
    begin
      exp_t e;
      @(negedge clk);
      chk("unstall_in_rdy", 32'(in_rdy), 1);
      e.pra = 8'd131; e.prb = 8'd1; e.prt = 8'd132; e.old = 8'd9; e.rtv = 1'b1;
      if (in_rdy) sb.push_back(e);
      @(posedge clk); #1;
    end
    issue(9, 10, 10, 1, 132, 10, 133, 10);
    chk("count_stall", 32'(dut.u_fl.count), 122);

    // Reset with an instruction stuck in the output register.
    idle(1);
    out_rdy = 1'b0;
    issue(1, 1, 11, 1, 1, 1, 134, 11);
    void'(sb.pop_back());
    rst = 1'b1;
    #1;
    chk("midrst_out_v", 32'(out_v), 0);
    chk("midrst_count", 32'(dut.u_fl.count), 128);
    idle(2);
    rst = 1'b0;
    out_rdy = 1'b1;
    issue(5, 6, 5, 1, 5, 6, 128, 5);

    for (int i = 0; i < 127; i++) begin
      int rt;
      int old;
      rt = i + 1;
      old = (rt == 5) ? 128 : rt;
      issue(rt, 0, rt, 1, old, 0, 129 + i, old);
    end
    chk("exhaust_empty", 32'(fl_empty), 1);
    chk("exhaust_count", 32'(dut.u_fl.count), 0);

    issue(3, 4, 9, 0, 131, 132, 0, 0);

    // Empty list: a renaming instruction waits; a same-cycle free is not usable yet.
    Ra = 7'd20; Rb = 7'd0; Rt = 7'd20; Rt_v = 1'b1; in_v = 1'b1;
    free_v = 1'b1; free_preg = 8'd0;
    @(negedge clk);
    chk("empty_in_rdy0", 32'(in_rdy), 0);
    @(posedge clk); #1;
    free_preg = 8'd7;
    @(negedge clk);
    chk("empty_preg0_ignored", 32'(in_rdy), 0);
    @(posedge clk); #1;
    free_v = 1'b0;
    begin
      exp_t e;
      @(negedge clk);
      chk("freed_in_rdy", 32'(in_rdy), 1);
      e.pra = 8'd148; e.prb = 8'd0; e.prt = 8'd7; e.old = 8'd148; e.rtv = 1'b1;
      if (in_rdy) sb.push_back(e);
      @(posedge clk); #1;
      in_v = 1'b0;
    end
    chk("refill_empty", 32'(fl_empty), 1);

    // Overflow: free into a full list.
    idle(2);
    pulse_reset();
    free_v = 1'b1; free_preg = 8'd9;
    @(posedge clk); #1;
    free_v = 1'b0;
    chk("ovf_err", 32'(fl_err), 1);
    chk("ovf_count", 32'(dut.u_fl.count), 128);
    idle(3);
    chk("ovf_sticky", 32'(fl_err), 1);
    pulse_reset();
    #1;
    chk("ovf_cleared", 32'(fl_err), 0);

    idle(2);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
